// File: rtl/clock_controller_pkg.sv
// Shared types, defaults and the rate-divider period helper for the clock controller.
package clock_controller_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam int DEFAULT_CLOCK_HZ        = 100_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  // Divider period for a rate select; a period that shifts down to zero
  // is promoted to one so the divider ticks every cycle instead of never.
  function automatic logic [31:0] rate_period(logic [31:0] base, logic [3:0] sel);
    logic [31:0] p;
    p = base >> sel;
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/clock_controller_button_debouncer.sv
// Push-button front end: 2-flop synchronizer, stability debounce and
// rising-edge press pulse. Releases are debounced but produce no pulse.
module button_debouncer
  import clock_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);

  localparam logic [31:0] LAST_COUNT = 32'(DEBOUNCE_CYCLES - 1);

  logic        sync_a;
  logic        sync_b;
  logic        level;
  logic        level_q;
  logic [31:0] stable_count;

  // Synchronize the raw button, then accept a new level only after it has
  // disagreed with the current level for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a       <= 1'b0;
      sync_b       <= 1'b0;
      level        <= 1'b0;
      level_q      <= 1'b0;
      stable_count <= '0;
    end else begin
      sync_a  <= button;
      sync_b  <= sync_a;
      level_q <= level;
      if (sync_b == level) begin
        stable_count <= '0;
      end else if (stable_count == LAST_COUNT) begin
        level        <= sync_b;
        stable_count <= '0;
      end else begin
        stable_count <= stable_count + 32'd1;
      end
    end
  end

  // Both terms are flops, so the pulse is clean and lasts exactly one cycle.
  assign press = level & ~level_q;

endmodule

// File: rtl/clock_controller.sv
// Single-step / free-run CPU clock-enable generator with debounced button.
//
//   state | meaning
//   HALT  | idle; a press enters RUN (MODE=1) or STEP (MODE=0) unless HALT_REQ
//   RUN   | CPU_CLOCK_EN follows the rate-divider tick; press or HALT_REQ stops
//   STEP  | one cycle with CPU_CLOCK_EN high, then back to HALT
module clock_controller
  import clock_controller_pkg::*;
#(
  parameter int CLOCK_HZ        = DEFAULT_CLOCK_HZ,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        BUTTON,
  input  logic        MODE,
  input  logic [3:0]  SWITCH,
  input  logic        HALT_REQ,
  output logic        CPU_CLOCK_EN,
  output logic        RUNNING,
  output logic        SLOW_CLOCK,
  output logic [15:0] STEP_COUNT
);

  state_t      state;
  logic [31:0] div_count;
  logic [31:0] period;
  logic        press;
  logic        tick;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock (CLOCK),
    .reset (RESET),
    .button(BUTTON),
    .press (press)
  );

  // Period follows SWITCH every cycle; the >= compare lets a shortened
  // period fire immediately when the count already sits past its end.
  assign period = rate_period(32'(CLOCK_HZ), SWITCH);
  assign tick   = (state == RUN) && (div_count >= period - 32'd1);

  // Mode sequencing and the divider count, which only advances in RUN.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= HALT;
      div_count <= '0;
    end else begin
      case (state)
        HALT: begin
          div_count <= '0;
          if (press && !HALT_REQ) begin
            state <= MODE ? RUN : STEP;
          end
        end
        RUN: begin
          if (press || HALT_REQ) begin
            state     <= HALT;
            div_count <= '0;
          end else if (tick) begin
            div_count <= '0;
          end else begin
            div_count <= div_count + 32'd1;
          end
        end
        STEP: begin
          state     <= HALT;
          div_count <= '0;
        end
        default: begin
          state     <= HALT;
          div_count <= '0;
        end
      endcase
    end
  end

  // Running total of issued CPU steps; wraps naturally at 16 bits.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      STEP_COUNT <= '0;
    end else if (CPU_CLOCK_EN) begin
      STEP_COUNT <= STEP_COUNT + 16'd1;
    end
  end

  assign CPU_CLOCK_EN = (state == STEP) || tick;
  assign RUNNING      = (state == RUN);
  assign SLOW_CLOCK   = (state == RUN) && (div_count >= (period >> 1));

endmodule

// File: tb/tb_clock_controller.sv
// Self-checking bench for clock_controller with CLOCK_HZ=16, DEBOUNCE_CYCLES=4.
module tb_clock_controller;

  localparam int HZ = 16;
  localparam int DB = 4;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        BUTTON;
  logic        MODE;
  logic [3:0]  SWITCH;
  logic        HALT_REQ;
  logic        CPU_CLOCK_EN;
  logic        RUNNING;
  logic        SLOW_CLOCK;
  logic [15:0] STEP_COUNT;

  int n_cmp = 0;
  int n_bad = 0;

  clock_controller #(
    .CLOCK_HZ       (HZ),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .BUTTON      (BUTTON),
    .MODE        (MODE),
    .SWITCH      (SWITCH),
    .HALT_REQ    (HALT_REQ),
    .CPU_CLOCK_EN(CPU_CLOCK_EN),
    .RUNNING     (RUNNING),
    .SLOW_CLOCK  (SLOW_CLOCK),
    .STEP_COUNT  (STEP_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] period_of(logic [3:0] sw);
    logic [31:0] p;
    p = 32'(HZ) >> sw;
    if (p == 32'd0) p = 32'd1;
    return p;
  endfunction

  // Behavioural model: mode 0=halted, 1=free-running, 2=single step.
  int          m_state;
  logic [31:0] m_cnt;
  logic        m_s1, m_s2, m_db, m_press;
  logic        hist[$];
  logic [15:0] m_count;
  bit          m_valid = 0;

  // Advance the model on each rising edge from the inputs of the ended cycle.
  always @(posedge CLOCK) begin : mdl
    logic [31:0] per;
    logic        tick;
    logic        flip;
    if (RESET) begin
      m_state = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_db = 0; m_press = 0;
      m_count = 0; hist.delete(); m_valid = 1;
    end else if (m_valid) begin
      per  = period_of(SWITCH);
      tick = (m_state == 1) && (m_cnt >= per - 1);
      if ((m_state == 2) || tick) m_count = m_count + 16'd1;
      case (m_state)
        2: m_state = 0;
        0: if (m_press && !HALT_REQ) begin m_state = MODE ? 1 : 2; m_cnt = 0; end
        default: begin
          if (m_press || HALT_REQ) begin m_state = 0; m_cnt = 0; end
          else if (tick) m_cnt = 0;
          else m_cnt = m_cnt + 1;
        end
      endcase
      // Debounced level flips once the last DB synchronized samples all disagree with it.
      hist.push_back(m_s2);
      if (hist.size() > DB) void'(hist.pop_front());
      flip = (hist.size() == DB);
      for (int i = 0; i < hist.size(); i++) if (hist[i] == m_db) flip = 0;
      m_press = flip && !m_db;
      if (flip) m_db = !m_db;
      m_s2 = m_s1;
      m_s1 = BUTTON;
    end
  end

  // Compare every cycle, mid-cycle, against the model.
  always @(negedge CLOCK) begin : cmp
    logic [31:0] per;
    logic        e_run, e_en, e_slow;
    if (m_valid) begin
      per    = period_of(SWITCH);
      e_run  = (m_state == 1);
      e_en   = (m_state == 2) || (e_run && (m_cnt >= per - 1));
      e_slow = e_run && (m_cnt >= per / 2);
      chk("model_cpu_clock_en", 32'(CPU_CLOCK_EN), 32'(e_en));
      chk("model_running",      32'(RUNNING),      32'(e_run));
      chk("model_slow_clock",   32'(SLOW_CLOCK),   32'(e_slow));
      chk("model_step_count",   32'(STEP_COUNT),   32'(m_count));
    end
  end

  logic        en_log[64];
  logic        run_log[64];
  logic        slow_log[64];
  logic [15:0] step_log[64];

  task automatic next_cycle();
    @(posedge CLOCK);
    #2;
  endtask

  task automatic idle(int n);
    repeat (n) next_cycle();
  endtask

  // Record outputs for n cycles starting with the current one.
  task automatic watch(int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) next_cycle();
      @(negedge CLOCK);
      en_log[i]   = CPU_CLOCK_EN;
      run_log[i]  = RUNNING;
      slow_log[i] = SLOW_CLOCK;
      step_log[i] = STEP_COUNT;
    end
  endtask

  function automatic int count_en(int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (en_log[i]) c++;
    return c;
  endfunction

  function automatic int first_en(int n);
    for (int i = 0; i < n; i++) if (en_log[i]) return i;
    return -1;
  endfunction

  function automatic int count_run(int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (run_log[i]) c++;
    return c;
  endfunction

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int bounce_pulses;
    int guard;
    RESET = 1; BUTTON = 0; MODE = 0; SWITCH = 4'd0; HALT_REQ = 0;
    idle(3);
    RESET = 0;
    watch(2);
    chk("reset_en",    32'(en_log[0] | en_log[1]),     32'd0);
    chk("reset_run",   32'(run_log[0] | run_log[1]),   32'd0);
    chk("reset_slow",  32'(slow_log[0] | slow_log[1]), 32'd0);
    chk("reset_count", 32'(step_log[1]),               32'd0);

    // Clean single-step press
    next_cycle(); MODE = 0; BUTTON = 1;
    watch(16);
    chk("step_pulses",  32'(count_en(16)),  32'd1);
    chk("step_latency", 32'(first_en(16)),  32'd7);
    chk("step_running", 32'(count_run(16)), 32'd0);
    chk("step_count",   32'(step_log[15]),  32'd1);
    next_cycle(); BUTTON = 0; idle(10);

    // Bouncing button, then settled high
    bounce_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      BUTTON = ((i % 4) < 2);
      @(negedge CLOCK);
      if (CPU_CLOCK_EN) bounce_pulses++;
      next_cycle();
    end
    BUTTON = 1;
    watch(16);
    chk("bounce_quiet",   32'(bounce_pulses), 32'd0);
    chk("bounce_pulses",  32'(count_en(16)),  32'd1);
    chk("bounce_latency", 32'(first_en(16)),  32'd7);
    chk("bounce_count",   32'(step_log[15]),  32'd2);
    next_cycle(); BUTTON = 0; idle(10);

    // Free run, period 4
    MODE = 1; SWITCH = 4'd2; BUTTON = 1;
    watch(20);
    chk("run_first",   32'(first_en(20)), 32'd10);
    chk("run_second",  32'(en_log[14]),   32'd1);
    chk("run_third",   32'(en_log[18]),   32'd1);
    chk("run_npulse",  32'(count_en(20)), 32'd3);
    chk("run_entry0",  32'(run_log[6]),   32'd0);
    chk("run_entry1",  32'(run_log[7]),   32'd1);
    chk("slow_cnt1",   32'(slow_log[8]),  32'd0);
    chk("slow_cnt2",   32'(slow_log[9]),  32'd1);
    chk("slow_cnt3",   32'(slow_log[10]), 32'd1);
    chk("slow_cnt0",   32'(slow_log[11]), 32'd0);
    next_cycle(); BUTTON = 0; idle(8);
    BUTTON = 1;
    watch(12);
    chk("stop_before", 32'(run_log[6]), 32'd1);
    chk("stop_after",  32'(run_log[7]), 32'd0);
    next_cycle(); BUTTON = 0; idle(10);

    // Shrinking the period mid-count
    MODE = 1; SWITCH = 4'd0; BUTTON = 1;
    idle(17);
    SWITCH = 4'd3;
    watch(6);
    chk("shrink_now", 32'(en_log[0]), 32'd1);
    chk("shrink_p1",  32'(en_log[1]), 32'd0);
    chk("shrink_p2",  32'(en_log[2]), 32'd1);
    chk("shrink_p3",  32'(en_log[3]), 32'd0);
    chk("shrink_p4",  32'(en_log[4]), 32'd1);
    next_cycle(); HALT_REQ = 1;
    watch(2);
    chk("hreq_tick_en",  32'(en_log[0]),  32'd1);
    chk("hreq_tick_run", 32'(run_log[0]), 32'd1);
    chk("hreq_halted",   32'(run_log[1]), 32'd0);
    chk("hreq_no_en",    32'(en_log[1]),  32'd0);
    next_cycle(); BUTTON = 0; idle(10);

    // Press while HALT_REQ holds the controller in HALT
    MODE = 0; BUTTON = 1;
    watch(14);
    chk("blocked_en",  32'(count_en(14)),  32'd0);
    chk("blocked_run", 32'(count_run(14)), 32'd0);
    next_cycle(); HALT_REQ = 0;
    watch(6);
    chk("not_queued", 32'(count_en(6)), 32'd0);
    next_cycle(); BUTTON = 0; idle(10);

    // Drive STEP_COUNT to 0xFFFF with a one-cycle period, then one more step
    MODE = 1; SWITCH = 4'd15; BUTTON = 1;
    guard = 0;
    while (m_count != 16'hFFFE && guard < 70000) begin
      next_cycle();
      guard++;
    end
    chk("reach_fffe_bound", 32'(guard < 70000), 32'd1);
    HALT_REQ = 1;
    watch(3);
    chk("wrap_halted", 32'(run_log[1]),  32'd0);
    chk("wrap_ffff",   32'(step_log[2]), 32'hFFFF);
    next_cycle(); BUTTON = 0; HALT_REQ = 0; idle(10);
    MODE = 0; BUTTON = 1;
    watch(10);
    chk("wrap_step",   32'(first_en(10)), 32'd7);
    chk("wrap_zero",   32'(step_log[9]),  32'd0);
    next_cycle(); BUTTON = 0; idle(10);

    // Reset in the middle of RUN with the button still held
    MODE = 1; SWITCH = 4'd2; BUTTON = 1;
    idle(12);
    RESET = 1; MODE = 0;
    next_cycle(); RESET = 0;
    watch(10);
    chk("rst_run",     32'(run_log[0]),   32'd0);
    chk("rst_en",      32'(en_log[0]),    32'd0);
    chk("rst_slow",    32'(slow_log[0]),  32'd0);
    chk("rst_count",   32'(step_log[0]),  32'd0);
    chk("rst_redeb",   32'(first_en(10)), 32'd7);
    chk("rst_after",   32'(step_log[9]),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
